proc_fetch_unit: RTL
====================

Name: proc_fetch_unit

Overview:
- Parametrised F-stage successor to the base datapath's fixed PC register and mux.
- Owns pc_F, issues imem requests with up to p_max_inflight outstanding, and squashes stale responses after redirects.
- Buffers returned instructions and presents {pc, inst} to decode over val/rdy.
- Sits between the imem port and the D-stage pipeline register of the processor datapath.

Parameters:
- p_reset_vector, 32'h200, PC of the first fetch after reset.
- p_max_inflight, 2, maximum outstanding imem requests (1..8); also the response buffer depth.
- p_num_cores, 1, carried for core_id width compatibility; no functional effect here.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- imem_req_val  out  1  request valid
- imem_req_rdy  in  1  memory ready
- imem_req_addr  out  32  fetch address (equals pc_F)
- imem_resp_val  in  1  response valid
- imem_resp_rdy  out  1  always 1 (buffer space reserved at issue)
- imem_resp_data  in  32  instruction word
- redirect_val  in  1  redirect from D/X this cycle
- redirect_target  in  32  new PC; bits [1:0] forced to 0
- inst_val_F  out  1  instruction valid to decode
- inst_rdy_D  in  1  decode accepts
- inst_F  out  32  instruction
- pc_out_F  out  32  PC of inst_F

Behaviour:
- Reset (async assert): pc_F=p_reset_vector; inflight=0; drop_cnt=0; buffer empty. Outputs: imem_req_val=0, inst_val_F=0, inst_F=0, pc_out_F=0.
- Issue condition: imem_req_val = !reset && (inflight + buffer occupancy < p_max_inflight). On handshake, pc_F <= pc_F+4 (32-bit wrap; 32'hFFFFFFFC -> 0). A PC FIFO of depth p_max_inflight records each issued address.
- First request is issued in the first cycle after reset deasserts, with addr = p_reset_vector.
- Redirect (highest priority):
  - pc_F <= redirect_target.
  - drop_cnt <= inflight after this cycle's issue/response updates (the old-pc request issued in the redirect cycle counts).
  - Buffer flushed the same cycle; inst_val_F forced 0 that cycle.
- Response:
  - If drop_cnt>0: the response is discarded, drop_cnt decrements, and the PC FIFO pops.
  - Otherwise: {PC FIFO head, data} is enqueued.
  - inflight decrements either way.
- Simultaneous response and redirect: the arriving response is counted before the drop_cnt snapshot; it is never delivered.
- Decode handshake: inst_val_F && inst_rdy_D dequeues. Buffer output is registered, so the minimum latency is resp -> inst_val_F in the next cycle.
- Invariant: inflight + occupancy <= p_max_inflight, so imem_resp_rdy=1 is safe. An assertion fires on a response with inflight==0.
- Reset asserted mid-operation clears all state. Responses to pre-reset requests arriving after reset are ignored via the inflight==0 check.

Optional Feature:
- FETCH_STATS_EN defined: adds 32-bit counters stat_issued, stat_dropped, stat_stall_cycles. A stall cycle is imem_req_val && !imem_req_rdy. Counters are reset to 0 and wrap. Extra output ports expose them.
- FETCH_STATS_EN undefined: ports and counters are absent; no other behavioural difference.

Decomposition:
- Shared package proc_fetch_pkg:
  - typedef fetch_entry_t {pc[31:0], inst[31:0]}
  - constant FETCH_MAX_INFLIGHT_LIMIT=8
  - localparam function for the inflight counter width, $clog2(p_max_inflight+1)
- One sub-module, proc_fetch_fifo: parametrised depth/type, synchronous-flush FIFO. It is instantiated twice, as the PC FIFO and the response buffer.

Test Plan:
- Reset, imem always ready, 1-cycle response latency -> requests at 0x200, 0x204, 0x208 on consecutive cycles; decode sees pc 0x200, 0x204, 0x208 with the matching data.
- Two requests in flight (0x200, 0x204), redirect to 0x1000 -> both responses dropped, stat_dropped=2. The next delivered instruction has pc 0x1000, then 0x1004.
- inst_rdy_D=0 for 5 cycles, p_max_inflight=2 -> exactly 2 requests issued, then imem_req_val=0. On release, the instructions drain in order and issue resumes.
- Redirect in the same cycle a response arrives, inflight=1 -> that response is not delivered, drop_cnt=0 afterwards, the next request addr equals the target.
- imem_req_rdy=0 for 3 cycles -> addr held at 0x200, stat_stall_cycles=3.
- Reset asserted with 2 in flight, then late responses arrive -> no inst_val_F; next fetch addr is 0x200. pc_F wrap check: redirect to 0xFFFFFFFC, next addr 0x0.

Source files
------------

// File: rtl/proc_fetch_pkg.sv
// Shared types and sizing helpers for the fetch unit and its FIFOs.
package proc_fetch_pkg;

    localparam int FETCH_MAX_INFLIGHT_LIMIT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic int inflight_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/proc_fetch_fifo.sv
// Small circular FIFO with synchronous flush; used for the PC tags and the response buffer.
module proc_fetch_fifo
    import proc_fetch_pkg::*;
#(
    parameter int  p_depth = 2,
    parameter type t_data  = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_val,
    input  t_data                        enq_data,
    input  logic                         deq_val,
    output t_data                        head,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CNT_W = $clog2(p_depth + 1);

    t_data            mem [p_depth];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_enq;
    logic             do_deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_deq = deq_val && (count != '0);
    assign do_enq = enq_val && ((count != CNT_W'(p_depth)) || do_deq);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < p_depth; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

endmodule

// File: rtl/proc_fetch_unit.sv
// F-stage fetch unit: pipelined imem requests, redirect squashing, buffered {pc, inst} to decode.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module proc_fetch_unit
    import proc_fetch_pkg::*;
#(
    parameter logic [31:0] p_reset_vector = 32'h200,
    parameter int          p_max_inflight = 2,
    parameter int          p_num_cores    = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_val,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_val,
    output logic        imem_resp_rdy,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target,
    output logic        inst_val_F,
    input  logic        inst_rdy_D,
    output logic [31:0] inst_F,
    output logic [31:0] pc_out_F
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_dropped,
    output logic [31:0] stat_stall_cycles
`endif
);

    localparam int CNT_W = inflight_width(p_max_inflight);

    logic [31:0]      pc_f;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] pc_count;
    logic [CNT_W:0]   occ_sum;
    logic [31:0]      pc_head;
    fetch_entry_t     buf_head;
    fetch_entry_t     buf_enq_data;
    logic             buf_not_empty;
    logic             issue_fire;
    logic             resp_fire;
    logic             resp_drop;
    logic             buf_enq;
    logic             buf_deq;

    // Buffer slots are reserved at issue time, so a response always has somewhere to land.
    assign occ_sum       = {1'b0, inflight} + {1'b0, buf_count};
    assign imem_req_val  = !reset && (occ_sum < (CNT_W+1)'(p_max_inflight));
    assign imem_req_addr = pc_f;
    assign imem_resp_rdy = 1'b1;
    assign issue_fire    = imem_req_val && imem_req_rdy;

    assign resp_fire     = imem_resp_val && (inflight != '0);
    assign resp_drop     = resp_fire && ((drop_cnt != '0) || redirect_val);
    assign buf_enq       = resp_fire && !resp_drop;
    assign buf_enq_data  = '{pc: pc_head, inst: imem_resp_data};
    assign inflight_next = inflight + CNT_W'(issue_fire) - CNT_W'(resp_fire);

    assign buf_not_empty = (buf_count != '0);
    assign inst_val_F    = buf_not_empty && !redirect_val;
    assign buf_deq       = inst_val_F && inst_rdy_D;
    assign inst_F        = buf_not_empty ? buf_head.inst : '0;
    assign pc_out_F      = buf_not_empty ? buf_head.pc : '0;

    proc_fetch_fifo #(
        .p_depth (p_max_inflight),
        .t_data  (logic [31:0])
    ) u_pc_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (1'b0),
        .enq_val  (issue_fire),
        .enq_data (pc_f),
        .deq_val  (resp_fire),
        .head     (pc_head),
        .count    (pc_count)
    );

    proc_fetch_fifo #(
        .p_depth (p_max_inflight),
        .t_data  (fetch_entry_t)
    ) u_resp_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_val),
        .enq_val  (buf_enq),
        .enq_data (buf_enq_data),
        .deq_val  (buf_deq),
        .head     (buf_head),
        .count    (buf_count)
    );

    // A redirect snapshots everything still outstanding, including this cycle's issue, as stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f     <= p_reset_vector;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_val) begin
                pc_f     <= {redirect_target[31:2], 2'b00};
                drop_cnt <= inflight_next;
            end else begin
                if (issue_fire) begin
                    pc_f <= pc_f + 32'd4;
                end
                if (resp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued       <= '0;
            stat_dropped      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_issued       <= stat_issued + 32'(issue_fire);
            stat_dropped      <= stat_dropped + 32'(resp_drop);
            stat_stall_cycles <= stat_stall_cycles + 32'(imem_req_val && !imem_req_rdy);
        end
    end
`endif

    a_params_legal: assert property (@(posedge clk) disable iff (reset)
        (p_max_inflight >= 1) && (p_max_inflight <= FETCH_MAX_INFLIGHT_LIMIT) && (p_num_cores >= 1));

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_val |-> (inflight != '0));

    a_pc_tags_track_inflight: assert property (@(posedge clk) disable iff (reset)
        pc_count == inflight);

endmodule
